// File: rtl/lfsr16_checker.sv
// Receive-side checker for the 16-state LFSR generator: self-synchronises to the
// serial stream, reports lock and sequence phase, and counts bit errors while locked.
`timescale 1ns/1ps
module lfsr16_checker #(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             din,
    input  logic             err_clr,
    output logic             locked,
    output logic [3:0]       phase,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [7:0]       LOCK_C   = 8'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_C = 4'(UNLOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    // Sequence index of a generator state (hist[0] is the newest bit).
    function automatic logic [3:0] hist_to_idx(input logic [3:0] h);
        logic [3:0] idx;
        case (h)
            4'b0000: idx = 4'd0;
            4'b0001: idx = 4'd1;
            4'b0011: idx = 4'd2;
            4'b0111: idx = 4'd3;
            4'b1111: idx = 4'd4;
            4'b1110: idx = 4'd5;
            4'b1101: idx = 4'd6;
            4'b1010: idx = 4'd7;
            4'b0101: idx = 4'd8;
            4'b1011: idx = 4'd9;
            4'b0110: idx = 4'd10;
            4'b1100: idx = 4'd11;
            4'b1001: idx = 4'd12;
            4'b0010: idx = 4'd13;
            4'b0100: idx = 4'd14;
            4'b1000: idx = 4'd15;
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       hist_q, hist_d;
    logic [1:0]       fill_q, fill_d;
    logic [7:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic             locked_q, locked_d;
    logic [3:0]       phase_q, phase_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic       pred_s;
    logic       match_s;
    logic [3:0] hist_next_s;
    logic [7:0] run_inc_s;
    logic [3:0] miss_inc_s;

    // Next-state logic: prediction, FSM transitions, phase and error bookkeeping.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        run_d       = run_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        phase_d     = phase_q;
        err_d       = 1'b0;
        wrap_d      = 1'b0;
        err_cnt_d   = err_cnt_q;
        pred_s      = hist_q[3] ^ hist_q[0] ^ ~(|hist_q[2:0]);
        match_s     = (din == pred_s);
        hist_next_s = {hist_q[2:0], din};
        run_inc_s   = run_q + 8'd1;
        miss_inc_s  = miss_q + 4'd1;

        if (cen) begin
            hist_d = hist_next_s;
            case (state_q)
                ST_FILL: begin
                    if (fill_q == 2'd3) begin
                        state_d = ST_TRACK;
                        fill_d  = 2'd0;
                        run_d   = 8'd0;
                    end else begin
                        fill_d = fill_q + 2'd1;
                    end
                end
                ST_TRACK: begin
                    if (!match_s) begin
                        run_d = 8'd0;
                    end else if (run_inc_s == LOCK_C) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                        phase_d  = hist_to_idx(hist_next_s);
                        miss_d   = 4'd0;
                        run_d    = 8'd0;
                    end else begin
                        run_d = run_inc_s;
                    end
                end
                ST_LOCKED: begin
                    // Phase free-runs once locked; mispredictions do not slip it.
                    phase_d = phase_q + 4'd1;
                    wrap_d  = (phase_q == 4'd15);
                    if (match_s) begin
                        miss_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + ERR_ONE;
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                        if (miss_inc_s == UNLOCK_C) begin
                            state_d  = ST_TRACK;
                            locked_d = 1'b0;
                            run_d    = 8'd0;
                            miss_d   = 4'd0;
                            phase_d  = 4'd0;
                            wrap_d   = 1'b0;
                        end else begin
                            miss_d = miss_inc_s;
                        end
                    end
                end
                default: begin
                    state_d  = ST_FILL;
                    fill_d   = 2'd0;
                    run_d    = 8'd0;
                    miss_d   = 4'd0;
                    locked_d = 1'b0;
                    phase_d  = 4'd0;
                end
            endcase
        end else begin
            hist_d = hist_q;
        end

        // A clear beats a same-cycle increment; that error is deliberately dropped.
        if (err_clr) begin
            err_cnt_d = '0;
        end else begin
            err_cnt_d = err_cnt_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_FILL;
            hist_q    <= 4'd0;
            fill_q    <= 2'd0;
            run_q     <= 8'd0;
            miss_q    <= 4'd0;
            locked_q  <= 1'b0;
            phase_q   <= 4'd0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            run_q     <= run_d;
            miss_q    <= miss_d;
            locked_q  <= locked_d;
            phase_q   <= phase_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked  = locked_q;
    assign phase   = phase_q;
    assign err     = err_q;
    assign wrap    = wrap_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_lfsr16_checker.sv
// Scoreboard bench for lfsr16_checker: two instances (ERR_W=16 and ERR_W=2) share
// one directed stimulus stream; expected outputs are queued per driven cycle.
`timescale 1ns/1ps
module tb_lfsr16_checker;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        din;
    logic        err_clr;
    logic        locked_a, err_a, wrap_a;
    logic [3:0]  phase_a;
    logic [15:0] cnt_a;
    logic        locked_b, err_b, wrap_b;
    logic [3:0]  phase_b;
    logic [1:0]  cnt_b;

    typedef struct packed {
        logic        l;
        logic [3:0]  p;
        logic        e;
        logic        w;
        logic [15:0] c;
        logic [1:0]  c2;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   n_pop;

    lfsr16_checker #(.LOCK_CNT(8), .UNLOCK_CNT(3), .ERR_W(16)) dut_a (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .err_clr(err_clr),
        .locked(locked_a), .phase(phase_a), .err(err_a), .wrap(wrap_a), .err_cnt(cnt_a)
    );

    lfsr16_checker #(.LOCK_CNT(8), .UNLOCK_CNT(3), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .err_clr(err_clr),
        .locked(locked_b), .phase(phase_b), .err(err_b), .wrap(wrap_b), .err_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator output bit that moves the sequence to index i (16'h135E: bit i).
    function automatic logic bit_of(input int i);
        logic [15:0] v;
        v = 16'h135E;
        return v[i % 16];
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step=%0d got=%0h exp=%0h", name, n_pop, got, want);
        end
    endtask

    task automatic step(input logic c, input logic d, input logic clr,
                        input logic el, input logic [3:0] ep, input logic ee,
                        input logic ew, input logic [15:0] ec, input logic [1:0] ec2);
        exp_t x;
        @(negedge clk);
        cen     = c;
        din     = d;
        err_clr = clr;
        x = '{l: el, p: ep, e: ee, w: ew, c: ec, c2: ec2};
        exp_q.push_back(x);
    endtask

    task automatic idle();
        @(negedge clk);
        cen     = 1'b0;
        din     = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_locked"}, 16'(locked_a) | 16'(locked_b), 16'd0);
        chk({tag, "_phase"},  16'(phase_a)  | 16'(phase_b),  16'd0);
        chk({tag, "_err"},    16'(err_a)    | 16'(err_b),    16'd0);
        chk({tag, "_wrap"},   16'(wrap_a)   | 16'(wrap_b),   16'd0);
        chk({tag, "_cnt"},    cnt_a | 16'(cnt_b),            16'd0);
    endtask

    // Monitor: one expected entry per driven cycle, compared just after the edge.
    initial begin
        exp_t x;
        n_pop = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_pop++;
                chk("a_locked", 16'(locked_a), 16'(x.l));
                chk("a_phase",  16'(phase_a),  16'(x.p));
                chk("a_err",    16'(err_a),    16'(x.e));
                chk("a_wrap",   16'(wrap_a),   16'(x.w));
                chk("a_errcnt", cnt_a,         x.c);
                chk("b_locked", 16'(locked_b), 16'(x.l));
                chk("b_phase",  16'(phase_b),  16'(x.p));
                chk("b_errcnt", 16'(cnt_b),    16'(x.c2));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        cen     = 1'b0;
        din     = 1'b0;
        err_clr = 1'b0;
        rst     = 1'b1;
        #3 rst  = 1'b0;
        #9;
        check_zero("rst_init");
        @(negedge clk);
        rst = 1'b1;

        // Lock on the reference stream from index 1; lock at index 12, wrap at 15->0.
        for (int i = 1; i < 12; i++) step(1'b1, bit_of(i), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 2'd0);
        step(1'b1, bit_of(12), 1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 16'd0, 2'd0);
        for (int i = 13; i < 16; i++) step(1'b1, bit_of(i), 1'b0, 1'b1, 4'(i), 1'b0, 1'b0, 16'd0, 2'd0);
        step(1'b1, bit_of(0), 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 16'd0, 2'd0);
        for (int i = 1; i < 4; i++) step(1'b1, bit_of(i), 1'b0, 1'b1, 4'(i), 1'b0, 1'b0, 16'd0, 2'd0);

        // cen toggling: cen=0 cycles freeze phase (and drop wrap) even with a wrong din.
        for (int i = 4; i < 20; i++) begin
            step(1'b0, ~bit_of(i), 1'b0, 1'b1, 4'((i - 1) % 16), 1'b0, 1'b0, 16'd0, 2'd0);
            step(1'b1, bit_of(i), 1'b0, 1'b1, 4'(i % 16), 1'b0, (i % 16 == 0), 16'd0, 2'd0);
        end

        // One inverted bit at index 4: misses at 4, 5 and 8, stream resyncs, lock held.
        step(1'b1, 1'b0,      1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 16'd1, 2'd1);
        step(1'b1, bit_of(5), 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 16'd2, 2'd2);
        step(1'b1, bit_of(6), 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 16'd2, 2'd2);
        step(1'b1, bit_of(7), 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 16'd2, 2'd2);
        step(1'b1, bit_of(8), 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 16'd3, 2'd3);
        for (int i = 9; i < 12; i++) step(1'b1, bit_of(i), 1'b0, 1'b1, 4'(i), 1'b0, 1'b0, 16'd3, 2'd3);

        // Constant 0: miss, match, miss, miss, miss -> unlock (wrap suppressed); B saturated.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd12, 1'b1, 1'b0, 16'd4, 2'd3);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd13, 1'b0, 1'b0, 16'd4, 2'd3);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd14, 1'b1, 1'b0, 16'd5, 2'd3);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 16'd6, 2'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 16'd7, 2'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 16'd7, 2'd3);
        // TRACK: 5 matches, a miss resets the run, then 8 matches relock at index 3.
        for (int i = 1; i < 6; i++) step(1'b1, bit_of(i), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd7, 2'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd7, 2'd3);
        for (int i = 12; i < 19; i++) step(1'b1, bit_of(i), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd7, 2'd3);
        step(1'b1, bit_of(3), 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 16'd7, 2'd3);
        step(1'b1, bit_of(4), 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 16'd7, 2'd3);

        // err_clr with a simultaneous error wins; counting then resumes from zero.
        step(1'b1, ~bit_of(5), 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 16'd0, 2'd0);
        step(1'b1, 1'b0,       1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 16'd0, 2'd0);
        step(1'b1, bit_of(6),  1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 16'd0, 2'd0);
        step(1'b1, bit_of(7),  1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 16'd0, 2'd0);
        step(1'b1, ~bit_of(8), 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 16'd1, 2'd1);

        // Asynchronous reset between edges, then relock after 4 + 8 accepted bits.
        idle();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 9; i < 20; i++) step(1'b1, bit_of(i), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 2'd0);
        step(1'b1, bit_of(4), 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 16'd0, 2'd0);
        idle();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
